// File: rtl/control_sequencer_if.sv
// Handshake and control bundle between the instruction front end and control_sequencer.
interface control_sequencer_if #(
  parameter int unsigned OP_W    = 5,
  parameter int unsigned ALUOP_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [OP_W-1:0]    opcode;
  logic [ALUOP_W-1:0] aluop;
  logic               flush;
  logic               md_ready;
  logic               md_exception;
  logic               alu_ovf;
  logic               md_start;
  logic               md_sel;
  logic               md_timeout;
  logic               out_valid;
  logic               br_ctrl;
  logic               jp_ctrl;
  logic               ALUinB_ctrl;
  logic               DMwe_ctrl;
  logic               Rwe_ctrl;
  logic               Rdst_ctrl;
  logic               Rwd_ctrl;
  logic [ALUOP_W-1:0] ALUop_ctrl;
  logic               exc_we;
  logic [2:0]         exc_code;

  modport master (
    output in_valid, opcode, aluop, flush, md_ready, md_exception, alu_ovf,
    input  in_ready, md_start, md_sel, md_timeout, out_valid, br_ctrl, jp_ctrl, ALUinB_ctrl,
           DMwe_ctrl, Rwe_ctrl, Rdst_ctrl, Rwd_ctrl, ALUop_ctrl, exc_we, exc_code
  );

  modport slave (
    input  in_valid, opcode, aluop, flush, md_ready, md_exception, alu_ovf,
    output in_ready, md_start, md_sel, md_timeout, out_valid, br_ctrl, jp_ctrl, ALUinB_ctrl,
           DMwe_ctrl, Rwe_ctrl, Rdst_ctrl, Rwd_ctrl, ALUop_ctrl, exc_we, exc_code
  );
endinterface

// File: rtl/control_sequencer.sv
// Decodes instructions into registered datapath controls and sequences multi-cycle mul/div.
// Exception status reporting is built only when CTRL_EXC_EN is defined.
module control_sequencer #(
  parameter int unsigned OP_W       = 5,
  parameter int unsigned ALUOP_W    = 5,
  parameter int unsigned MD_TIMEOUT = 64
) (
  input logic                clk,
  input logic                rst,
  control_sequencer_if.slave bus
);
  localparam int unsigned     CntW    = $clog2(MD_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(MD_TIMEOUT - 1);

  typedef enum logic [0:0] {StIdle, StMdWait} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [ALUOP_W-1:0] md_aluop_q, md_aluop_d;
  logic               md_sel_q, md_sel_d;
  logic               md_start_q, md_start_d;
  logic               md_timeout_q, md_timeout_d;
  logic               out_valid_q, out_valid_d;
  logic               br_q, br_d, jp_q, jp_d, alu_inb_q, alu_inb_d, dm_we_q, dm_we_d;
  logic               rwe_q, rwe_d, rdst_q, rdst_d, rwd_q, rwd_d;
  logic [ALUOP_W-1:0] aluop_q, aluop_d;

  logic is_r, is_j, is_bne, is_jal, is_jr, is_addi, is_blt, is_sw, is_lw, is_md;
  logic in_ready, accept, issue, md_done;

  always_comb begin
    is_r    = bus.opcode == OP_W'(0);
    is_j    = bus.opcode == OP_W'(1);
    is_bne  = bus.opcode == OP_W'(2);
    is_jal  = bus.opcode == OP_W'(3);
    is_jr   = bus.opcode == OP_W'(4);
    is_addi = bus.opcode == OP_W'(5);
    is_blt  = bus.opcode == OP_W'(6);
    is_sw   = bus.opcode == OP_W'(7);
    is_lw   = bus.opcode == OP_W'(8);
    is_md   = is_r & ((bus.aluop == ALUOP_W'(6)) | (bus.aluop == ALUOP_W'(7)));
  end

  assign in_ready = (state_q == StIdle);
  assign accept   = bus.in_valid & in_ready & ~bus.flush;
  assign issue    = accept & ~is_md;
  // The first wait cycle (counter still 0) ignores md_ready; flush always wins.
  assign md_done  = (state_q == StMdWait) & ~bus.flush & bus.md_ready & (cnt_q != '0);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    md_aluop_d   = md_aluop_q;
    md_sel_d     = md_sel_q;
    md_start_d   = 1'b0;
    md_timeout_d = 1'b0;
    out_valid_d  = 1'b0;
    br_d         = 1'b0;
    jp_d         = 1'b0;
    alu_inb_d    = 1'b0;
    dm_we_d      = 1'b0;
    rwe_d        = 1'b0;
    rdst_d       = 1'b0;
    rwd_d        = 1'b0;
    aluop_d      = '0;
    unique case (state_q)
      StIdle: begin
        if (accept && is_md) begin
          state_d    = StMdWait;
          cnt_d      = '0;
          md_aluop_d = bus.aluop;
          md_sel_d   = (bus.aluop == ALUOP_W'(7));
          md_start_d = 1'b1;
        end else if (issue) begin
          out_valid_d = 1'b1;
          br_d        = is_bne | is_blt;
          jp_d        = is_j | is_jal | is_jr;
          alu_inb_d   = is_addi | is_lw | is_sw;
          dm_we_d     = is_sw;
          rwe_d       = is_r | is_addi | is_lw | is_jal;
          rdst_d      = is_r;
          rwd_d       = is_lw;
          if (is_r) begin
            aluop_d = bus.aluop;
          end else if (is_bne || is_blt) begin
            aluop_d = ALUOP_W'(1);
          end
        end
      end
      StMdWait: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.flush) begin
          state_d = StIdle;
        end else if (md_done) begin
          state_d     = StIdle;
          out_valid_d = 1'b1;
          rwe_d       = 1'b1;
          rdst_d      = 1'b1;
          aluop_d     = md_aluop_q;
        end else if (cnt_q == CntLast) begin
          state_d      = StIdle;
          out_valid_d  = 1'b1;
          md_timeout_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      md_aluop_q   <= '0;
      md_sel_q     <= 1'b0;
      md_start_q   <= 1'b0;
      md_timeout_q <= 1'b0;
      out_valid_q  <= 1'b0;
      br_q         <= 1'b0;
      jp_q         <= 1'b0;
      alu_inb_q    <= 1'b0;
      dm_we_q      <= 1'b0;
      rwe_q        <= 1'b0;
      rdst_q       <= 1'b0;
      rwd_q        <= 1'b0;
      aluop_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      md_aluop_q   <= md_aluop_d;
      md_sel_q     <= md_sel_d;
      md_start_q   <= md_start_d;
      md_timeout_q <= md_timeout_d;
      out_valid_q  <= out_valid_d;
      br_q         <= br_d;
      jp_q         <= jp_d;
      alu_inb_q    <= alu_inb_d;
      dm_we_q      <= dm_we_d;
      rwe_q        <= rwe_d;
      rdst_q       <= rdst_d;
      rwd_q        <= rwd_d;
      aluop_q      <= aluop_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.md_start    = md_start_q;
  assign bus.md_sel      = md_sel_q;
  assign bus.md_timeout  = md_timeout_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.br_ctrl     = br_q;
  assign bus.jp_ctrl     = jp_q;
  assign bus.ALUinB_ctrl = alu_inb_q;
  assign bus.DMwe_ctrl   = dm_we_q;
  assign bus.Rdst_ctrl   = rdst_q;
  assign bus.Rwd_ctrl    = rwd_q;
  assign bus.ALUop_ctrl  = aluop_q;

`ifdef CTRL_EXC_EN
  // Nonzero code marks an output whose overflow (or MD exception) raises that code.
  logic [2:0] ovf_code_q, ovf_code_d, md_exc_q, md_exc_d;
  logic       exc_we;

  always_comb begin
    ovf_code_d = 3'd0;
    if (issue && is_r && (bus.aluop == ALUOP_W'(0))) begin
      ovf_code_d = 3'd1;
    end else if (issue && is_addi) begin
      ovf_code_d = 3'd2;
    end else if (issue && is_r && (bus.aluop == ALUOP_W'(1))) begin
      ovf_code_d = 3'd3;
    end
    md_exc_d = (md_done && bus.md_exception) ? (md_sel_q ? 3'd5 : 3'd4) : 3'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_code_q <= 3'd0;
      md_exc_q   <= 3'd0;
    end else begin
      ovf_code_q <= ovf_code_d;
      md_exc_q   <= md_exc_d;
    end
  end

  assign exc_we       = out_valid_q & ((bus.alu_ovf & (ovf_code_q != 3'd0)) | (md_exc_q != 3'd0));
  assign bus.exc_we   = exc_we;
  assign bus.exc_code = exc_we ? ((md_exc_q != 3'd0) ? md_exc_q : ovf_code_q) : 3'd0;
  assign bus.Rwe_ctrl = rwe_q & ~exc_we;
`else
  logic unused_exc_inputs;
  assign unused_exc_inputs = bus.alu_ovf ^ bus.md_exception;
  assign bus.exc_we        = 1'b0;
  assign bus.exc_code      = 3'd0;
  assign bus.Rwe_ctrl      = rwe_q;
`endif
endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus queues expected outputs, a negedge monitor
// pops and compares on every out_valid and checks bubbles otherwise.
module tb_control_sequencer;
  localparam int unsigned MdTimeout = 6;

  localparam logic [6:0] CBr   = 7'b1000000;
  localparam logic [6:0] CJp   = 7'b0100000;
  localparam logic [6:0] CAlub = 7'b0010000;
  localparam logic [6:0] CDmwe = 7'b0001000;
  localparam logic [6:0] CRwe  = 7'b0000100;
  localparam logic [6:0] CRdst = 7'b0000010;
  localparam logic [6:0] CRwd  = 7'b0000001;

  typedef struct packed {
    logic [6:0] ctl;  // {br, jp, alu_inb, dm_we, rwe, rdst, rwd}
    logic [4:0] aluop;
    logic       tmo;
    logic       exc_we;
    logic [2:0] exc_code;
  } resp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  ovf_pipe = 1'b0;
  int    n_tests = 0;
  int    n_fail = 0;
  int    md_start_seen = 0;
  resp_t sb[$];

  control_sequencer_if #(.OP_W(5), .ALUOP_W(5)) bus ();

  control_sequencer #(.OP_W(5), .ALUOP_W(5), .MD_TIMEOUT(MdTimeout)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic resp_t mk(input logic [6:0] ctl, input logic [4:0] al, input logic tmo,
                               input logic [2:0] exc);
    resp_t r;
    r.ctl   = ctl;
    r.aluop = al;
    r.tmo   = tmo;
`ifdef CTRL_EXC_EN
    r.exc_we   = (exc != 3'd0);
    r.exc_code = exc;
    if (exc != 3'd0) r.ctl[2] = 1'b0;
`else
    r.exc_we   = 1'b0;
    r.exc_code = 3'd0;
`endif
    return r;
  endfunction

  function automatic resp_t actual();
    return {bus.br_ctrl, bus.jp_ctrl, bus.ALUinB_ctrl, bus.DMwe_ctrl, bus.Rwe_ctrl,
            bus.Rdst_ctrl, bus.Rwd_ctrl, bus.ALUop_ctrl, bus.md_timeout, bus.exc_we,
            bus.exc_code};
  endfunction

  always @(negedge clk) begin
    resp_t act;
    resp_t exp;
    act = actual();
    if (bus.md_start) md_start_seen++;
    if (bus.out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 32'(act), 32'h1ffff);
      end else begin
        exp = sb.pop_front();
        check("out_resp", 32'(act), 32'(exp));
      end
    end else begin
      check("bubble", 32'(act), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus.alu_ovf      = ovf_pipe;
    ovf_pipe         = 1'b0;
    bus.in_valid     = 1'b0;
    bus.flush        = 1'b0;
    bus.md_ready     = 1'b0;
    bus.md_exception = 1'b0;
    bus.opcode       = 5'd0;
    bus.aluop        = 5'd0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [4:0] op, input logic [4:0] al, input logic ovf,
                      input logic push, input resp_t exp);
    check("in_ready_on_issue", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.aluop    = al;
    ovf_pipe     = ovf;
    if (push) sb.push_back(exp);
    tick();
  endtask

  // ready_from: first wait cycle with md_ready high (0 = never); flush_at: 0 = never.
  task automatic md_op(input logic [4:0] al, input int ready_from, input logic exc,
                       input int flush_at, input logic [2:0] code);
    int   starts;
    logic done;
    starts = md_start_seen;
    done   = 1'b0;
    send(5'd0, al, 1'b0, 1'b0, '0);
    for (int c = 1; c <= int'(MdTimeout) && !done; c++) begin
      check("md_in_ready_low", 32'(bus.in_ready), 32'd0);
      if (c == 1) begin
        check("md_start_first", 32'(bus.md_start), 32'd1);
        check("md_sel", 32'(bus.md_sel), 32'(al == 5'd7));
      end
      bus.md_ready     = (ready_from != 0) && (c >= ready_from);
      bus.md_exception = exc;
      if (c == flush_at) begin
        bus.flush = 1'b1;
        done      = 1'b1;
      end else if (bus.md_ready && c > 1) begin
        sb.push_back(mk(CRwe | CRdst, al, 1'b0, exc ? code : 3'd0));
        done = 1'b1;
      end else if (c == int'(MdTimeout)) begin
        sb.push_back(mk(7'd0, 5'd0, 1'b1, 3'd0));
        done = 1'b1;
      end
      tick();
    end
    check("in_ready_after_md", 32'(bus.in_ready), 32'd1);
    tick();
    check("md_start_once", 32'(md_start_seen - starts), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1);
  end

  initial begin
    int starts;
    bus.in_valid     = 1'b0;
    bus.opcode       = 5'd0;
    bus.aluop        = 5'd0;
    bus.flush        = 1'b0;
    bus.md_ready     = 1'b0;
    bus.md_exception = 1'b0;
    bus.alu_ovf      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_md_start", 32'(bus.md_start), 32'd0);
    check("reset_outputs", 32'(actual()), 32'd0);
    rst = 1'b0;
    idle(2);

    // addi, then back-to-back sw, lw, bne, jal
    send(5'd5, 5'd0, 1'b0, 1'b1, mk(CAlub | CRwe, 5'd0, 1'b0, 3'd0));
    send(5'd7, 5'd3, 1'b0, 1'b1, mk(CAlub | CDmwe, 5'd0, 1'b0, 3'd0));
    send(5'd8, 5'd31, 1'b0, 1'b1, mk(CAlub | CRwe | CRwd, 5'd0, 1'b0, 3'd0));
    send(5'd2, 5'd0, 1'b0, 1'b1, mk(CBr, 5'd1, 1'b0, 3'd0));
    send(5'd3, 5'd0, 1'b0, 1'b1, mk(CJp | CRwe, 5'd0, 1'b0, 3'd0));
    // remaining opcodes and undefined ones
    send(5'd0, 5'd3, 1'b0, 1'b1, mk(CRwe | CRdst, 5'd3, 1'b0, 3'd0));
    send(5'd0, 5'd31, 1'b0, 1'b1, mk(CRwe | CRdst, 5'd31, 1'b0, 3'd0));
    send(5'd1, 5'd0, 1'b0, 1'b1, mk(CJp, 5'd0, 1'b0, 3'd0));
    send(5'd4, 5'd0, 1'b0, 1'b1, mk(CJp, 5'd0, 1'b0, 3'd0));
    send(5'd6, 5'd9, 1'b0, 1'b1, mk(CBr, 5'd1, 1'b0, 3'd0));
    send(5'd9, 5'd2, 1'b0, 1'b1, mk(7'd0, 5'd0, 1'b0, 3'd0));
    send(5'd31, 5'd0, 1'b0, 1'b1, mk(7'd0, 5'd0, 1'b0, 3'd0));
    idle(1);

    // flush blocks an accept in IDLE
    bus.in_valid = 1'b1;
    bus.opcode   = 5'd5;
    bus.flush    = 1'b1;
    tick();
    idle(2);

    // overflow exceptions: add, addi, sub raise; lw and R aluop 2 do not
    send(5'd0, 5'd0, 1'b1, 1'b1, mk(CRwe | CRdst, 5'd0, 1'b0, 3'd1));
    send(5'd5, 5'd0, 1'b1, 1'b1, mk(CAlub | CRwe, 5'd0, 1'b0, 3'd2));
    send(5'd0, 5'd1, 1'b1, 1'b1, mk(CRwe | CRdst, 5'd1, 1'b0, 3'd3));
    send(5'd8, 5'd0, 1'b1, 1'b1, mk(CAlub | CRwe | CRwd, 5'd0, 1'b0, 3'd0));
    send(5'd0, 5'd2, 1'b1, 1'b1, mk(CRwe | CRdst, 5'd2, 1'b0, 3'd0));
    send(5'd0, 5'd0, 1'b0, 1'b1, mk(CRwe | CRdst, 5'd0, 1'b0, 3'd0));
    idle(1);

    md_op(5'd6, 5, 1'b0, 0, 3'd0);                     // mul, ready on 5th wait cycle
    md_op(5'd7, 0, 1'b0, 0, 3'd0);                     // div, timeout
    md_op(5'd7, int'(MdTimeout), 1'b0, 0, 3'd0);       // ready on the timeout cycle
    md_op(5'd6, 1, 1'b0, 0, 3'd0);                     // ready in first cycle ignored
    md_op(5'd7, 3, 1'b0, 3, 3'd0);                     // flush beats md_ready
    idle(int'(MdTimeout) + 2);
    md_op(5'd6, 2, 1'b1, 0, 3'd4);                     // mul exception
    md_op(5'd7, 4, 1'b1, 0, 3'd5);                     // div exception
    send(5'd5, 5'd0, 1'b0, 1'b1, mk(CAlub | CRwe, 5'd0, 1'b0, 3'd0));
    idle(1);

    // reset in the middle of MD_WAIT drops the operation
    starts = md_start_seen;
    send(5'd0, 5'd7, 1'b0, 1'b0, '0);
    idle(2);
    rst = 1'b1;
    #1;
    check("rst_md_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_md_outputs", 32'({bus.out_valid, bus.md_start, actual()}), 32'd0);
    idle(2);
    rst = 1'b0;
    idle(int'(MdTimeout) + 2);
    check("rst_md_start_count", 32'(md_start_seen - starts), 32'd1);

    // asynchronous reset clears a live output immediately
    send(5'd5, 5'd0, 1'b0, 1'b0, '0);
    check("pre_reset_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("async_reset_clear", 32'({bus.out_valid, actual()}), 32'd0);
    check("async_reset_ready", 32'(bus.in_ready), 32'd1);
    tick();
    rst = 1'b0;
    idle(2);
    send(5'd3, 5'd0, 1'b0, 1'b1, mk(CJp | CRwe, 5'd0, 1'b0, 3'd0));
    idle(2);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameters: OP_W, 5, opcode width; ALUOP_W, 5, ALU op width; MD_TIMEOUT, 64, max multdiv wait cycles (>=2).
REQ-002 clock  in  1  single clock, rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 in_valid  in  1  instruction present; in_ready  out  1  accept (combinational, 1 iff state IDLE).
REQ-005 opcode  in  OP_W; aluop  in  ALUOP_W; flush  in  1  discard accept/abort wait.
REQ-006 md_ready  in  1  multdiv result ready; md_exception  in  1; alu_ovf  in  1  ALU overflow in execute cycle.
REQ-007 md_start  out  1  one-cycle pulse; md_sel  out  1  0=mul 1=div; md_timeout  out  1  one-cycle pulse.
REQ-008 out_valid, br_ctrl, jp_ctrl, ALUinB_ctrl, DMwe_ctrl, Rwe_ctrl, Rdst_ctrl, Rwd_ctrl  out  1 each; ALUop_ctrl  out  ALUOP_W; all registered.
REQ-009 exc_we  out  1; exc_code  out  3  exception status write.

Function
REQ-010 Accept = in_valid & in_ready & !flush; non-MD accept SHALL produce out_valid=1 with decoded controls exactly 1 cycle later; no accept SHALL produce bubble (out_valid and all ctrl 0).
REQ-011 Decode (opcode decimal): 0 R, 1 j, 2 bne, 3 jal, 4 jr, 5 addi, 6 blt, 7 sw, 8 lw; any other opcode SHALL decode to all-zero ctrl with out_valid=1.
REQ-012 ALUinB=addi|lw|sw; DMwe=sw; Rwe=R|addi|lw|jal; Rdst=R; Rwd=lw; br=bne|blt; jp=j|jal|jr.
REQ-013 ALUop_ctrl=aluop for R, 00001 for bne/blt, 0 otherwise (zero-extended/truncated to ALUOP_W).
REQ-014 R with aluop 00110 (mul) or 00111 (div) SHALL be MD: FSM IDLE->MD_WAIT on accept, no out_valid on the next cycle.
REQ-015 First MD_WAIT cycle: md_start=1, md_sel latched; md_ready ignored in that cycle; wait counter cleared on entry, +1 per MD_WAIT cycle.
REQ-016 md_ready=1 in MD_WAIT (after first cycle): next cycle out_valid=1, Rwe=1, Rdst=1, ALUop_ctrl=latched aluop; FSM->IDLE.
REQ-017 Counter reaching MD_TIMEOUT without md_ready: md_timeout pulse and out_valid=1 with all ctrl 0; FSM->IDLE.
REQ-018 md_ready and timeout in same cycle: md_ready wins, no md_timeout.
REQ-019 flush=1: no accept; in MD_WAIT SHALL abort to IDLE next cycle with bubble, no md_timeout; flush beats md_ready.
REQ-020 in_ready SHALL be 0 in every MD_WAIT cycle including the completing one; back-to-back non-MD accepts every cycle SHALL be supported.

Reset
REQ-021 reset SHALL immediately force state IDLE, counter 0, every registered output 0; exc_we/exc_code 0; in_ready 1 while reset asserted.
REQ-022 Reset mid-MD_WAIT SHALL drop the pending operation with no out_valid, md_start or md_timeout afterwards.

Configuration
REQ-023 Macro CTRL_EXC_EN defined: exc_we=1, combinationally, when out_valid & alu_ovf for add(aluop 0, code 1), addi(code 2), sub(aluop 1, code 3), or on MD completion with md_exception registered at md_ready (mul code 4, div code 5); Rwe_ctrl SHALL be 0 when exc_we=1.
REQ-024 Macro undefined: exc_we and exc_code SHALL be constant 0, Rwe unaffected; port list identical.

Verification
REQ-025 Accept addi (5) at cycle N -> cycle N+1 out_valid=1, ALUinB=1, Rwe=1, ALUop=0, others 0.
REQ-026 Accept sw,lw,bne,jal back-to-back -> four consecutive out_valid cycles, ctrl per REQ-012, in_ready held 1.
REQ-027 Accept mul (op 0, aluop 00110), md_ready at 5th wait cycle -> md_start once, md_sel=0, in_ready=0 throughout, out_valid Rwe=1 Rdst=1 ALUop=00110 one cycle later.
REQ-028 Accept div, MD_TIMEOUT=4, md_ready never -> md_timeout pulse, out_valid with all ctrl 0, then IDLE; repeat with md_ready on timeout cycle -> normal completion.
REQ-029 flush during MD_WAIT, and reset during MD_WAIT -> IDLE, no out_valid, no md_timeout; reset outputs 0 immediately.
REQ-030 CTRL_EXC_EN, add with alu_ovf=1 -> exc_we=1, exc_code=1, Rwe=0; div with md_exception -> exc_code=5; macro undefined -> exc_we=0.
